bz_pll_reset_sequencer: RTL and testbench

//  Consumer side of the host-core PLL: drives the PLL's active-high rst and watches its async locked flag.

---
 rtl/bz_pll_seq_pkg.sv | 32 +++
 rtl/bz_pll_reset_sequencer_if.sv | 38 +++
 rtl/bz_sync_bit.sv | 27 ++
 rtl/bz_pll_reset_sequencer.sv | 164 ++++++++++++++++
 tb/tb_bz_pll_reset_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bz_pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bz_pll_seq_pkg
//  Description : Shared state encoding, default timing constants and helper
//                for the PLL reset sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package bz_pll_seq_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } seq_state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 100000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_SYNC_STAGES         = 2;
    localparam int LOCK_LOST_W             = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bz_pll_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bz_pll_reset_sequencer_if
//  Description : PLL control/status and fabric reset bundle of the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface bz_pll_reset_sequencer_if
    import bz_pll_seq_pkg::*;
();
    logic                   pll_locked;
    logic                   clear_fault;
    logic                   pll_rst;
    logic                   core_rst_n;
    logic                   pll_ready;
    logic                   fault;
    logic [LOCK_LOST_W-1:0] lock_lost_cnt;

    modport master (
        input  pll_locked,
        input  clear_fault,
        output pll_rst,
        output core_rst_n,
        output pll_ready,
        output fault,
        output lock_lost_cnt
    );

    modport slave (
        output pll_locked,
        output clear_fault,
        input  pll_rst,
        input  core_rst_n,
        input  pll_ready,
        input  fault,
        input  lock_lost_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bz_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : bz_sync_bit
//  Description : Multi-flop synchronizer for one asynchronous level signal.
//  Revision    : 1.0  initial release
// ============================================================================
module bz_sync_bit #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);
    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/bz_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bz_pll_reset_sequencer
//  Description : Pulses PLL reset, waits for and qualifies lock with retry,
//                then releases the fabric reset; re-runs on lock loss.
//  Revision    : 1.0  initial release
// ============================================================================
module bz_pll_reset_sequencer
    import bz_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
    input  wire logic                 refclk,
    input  wire logic                 rst_n,
    bz_pll_reset_sequencer_if.master  bus
);
    localparam int TIMER_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES)) + 1;
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] C_RST_LAST     = TIMER_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] C_TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] C_STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] C_RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    seq_state_t             r_state;
    seq_state_t             w_state_next;
    logic [TIMER_W-1:0]     r_timer;
    logic [RETRY_W-1:0]     r_retry;
    logic [RETRY_W-1:0]     w_retry_next;
    logic [LOCK_LOST_W-1:0] r_lock_lost_cnt;
    logic                   w_locked_s;
    logic                   w_attempt_fail;
    logic                   w_lock_lost;
    logic                   r_pll_rst;
    logic                   r_core_rst_n;
    logic                   r_pll_ready;
    logic                   r_fault;

    bz_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_locked_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (w_locked_s)
    );

    always_comb begin
        w_state_next   = r_state;
        w_retry_next   = r_retry;
        w_attempt_fail = 1'b0;
        w_lock_lost    = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_timer == C_RST_LAST) begin
                    w_state_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as a success.
                if (w_locked_s) begin
                    w_state_next = S_STABLE;
                end else if (r_timer == C_TIMEOUT_LAST) begin
                    w_attempt_fail = 1'b1;
                end
            end
            S_STABLE: begin
                if (!w_locked_s) begin
                    w_attempt_fail = 1'b1;
                end else if (r_timer == C_STABLE_LAST) begin
                    w_state_next = S_RUN;
                    w_retry_next = '0;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_next = S_PLL_RST;
                    w_retry_next = '0;
                    w_lock_lost  = 1'b1;
                end
            end
            S_FAULT: begin
                if (bus.clear_fault) begin
                    w_state_next = S_PLL_RST;
                    w_retry_next = '0;
                end
            end
            default: begin
                w_state_next = S_PLL_RST;
            end
        endcase

        if (w_attempt_fail) begin
            if (r_retry == C_RETRY_MAX) begin
                w_state_next = S_FAULT;
            end else begin
                w_state_next = S_PLL_RST;
                w_retry_next = r_retry + 1'b1;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state <= S_PLL_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every transition changes state, so a state change marks an entry.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_state_next != r_state) begin
            r_timer <= '0;
        end else if (r_state inside {S_PLL_RST, S_WAIT_LOCK, S_STABLE}) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_retry <= '0;
        end else begin
            r_retry <= w_retry_next;
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_lock_lost_cnt <= '0;
        end else if (w_lock_lost && (r_lock_lost_cnt != '1)) begin
            r_lock_lost_cnt <= r_lock_lost_cnt + 1'b1;
        end
    end

    // Outputs decoded from the next state so they move with the state register.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_pll_rst    <= 1'b1;
            r_core_rst_n <= 1'b0;
            r_pll_ready  <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_pll_rst    <= (w_state_next == S_PLL_RST) || (w_state_next == S_FAULT);
            r_core_rst_n <= (w_state_next == S_RUN);
            r_pll_ready  <= (w_state_next == S_RUN);
            r_fault      <= (w_state_next == S_FAULT);
        end
    end

    assign bus.pll_rst       = r_pll_rst;
    assign bus.core_rst_n    = r_core_rst_n;
    assign bus.pll_ready     = r_pll_ready;
    assign bus.fault         = r_fault;
    assign bus.lock_lost_cnt = r_lock_lost_cnt;
endmodule
`default_nettype wire

// File: tb/tb_bz_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bz_pll_reset_sequencer
//  Description : Directed and randomized bench with a countdown-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bz_pll_reset_sequencer;
    localparam int RST_PULSE = 4;
    localparam int TIMEOUT   = 50;
    localparam int STABLE    = 8;
    localparam int MAX_RETRY = 2;
    localparam int SYNC      = 2;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic refclk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    bz_pll_reset_sequencer_if sif ();

    bz_pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RST_PULSE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .LOCK_STABLE_CYCLES  (STABLE),
        .MAX_RETRIES         (MAX_RETRY),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (sif.master)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: phase plus cycles remaining in it, fed by a delay line of pll_locked.
    int   m_phase = P_RST;
    int   m_left  = RST_PULSE;
    int   m_fails = 0;
    int   m_cnt   = 0;
    bit   m_valid = 1'b0;
    logic m_sync [SYNC];
    logic m_ls;
    bit   m_fail;

    always @(posedge refclk) begin
        if (!rst_n) begin
            m_phase = P_RST;
            m_left  = RST_PULSE;
            m_fails = 0;
            m_cnt   = 0;
            m_valid = 1'b1;
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
        end else if (m_valid) begin
            m_ls = m_sync[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = sif.pll_locked;
            m_fail = 1'b0;
            case (m_phase)
                P_RST: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_WAIT; m_left = TIMEOUT; end
                end
                P_WAIT: begin
                    if (m_ls) begin m_phase = P_STABLE; m_left = STABLE; end
                    else begin m_left--; if (m_left == 0) m_fail = 1'b1; end
                end
                P_STABLE: begin
                    if (!m_ls) m_fail = 1'b1;
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_phase = P_RUN; m_fails = 0; end
                    end
                end
                P_RUN: begin
                    if (!m_ls) begin
                        m_phase = P_RST; m_left = RST_PULSE; m_fails = 0;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
                default: begin
                    if (sif.clear_fault) begin m_phase = P_RST; m_left = RST_PULSE; m_fails = 0; end
                end
            endcase
            if (m_fail) begin
                if (m_fails == MAX_RETRY) m_phase = P_FAULT;
                else begin m_fails++; m_phase = P_RST; m_left = RST_PULSE; end
            end
        end
    end

    always @(posedge refclk) begin
        #1;
        if (m_valid) begin
            check("cycle_outputs",
                  {20'd0, sif.pll_rst, sif.core_rst_n, sif.pll_ready, sif.fault, sif.lock_lost_cnt},
                  {20'd0, (m_phase == P_RST) || (m_phase == P_FAULT), m_phase == P_RUN,
                   m_phase == P_RUN, m_phase == P_FAULT, 8'(m_cnt)});
        end
    end

    function automatic logic pick(input int sel);
        case (sel)
            0:       return sif.pll_rst;
            1:       return sif.core_rst_n;
            2:       return sif.pll_ready;
            default: return sif.fault;
        endcase
    endfunction

    // Counts edges until the selected output reaches val; -1 and a FAIL on expiry.
    task automatic edges_until(input int sel, input logic val, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge refclk);
            #1;
            n++;
            if (pick(sel) === val) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_timeout sel=%0d actual=%b required=%b", sel, pick(sel), val);
        n = -1;
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst_n = 1'b0;
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        check("reset_ctrl", {28'd0, sif.pll_rst, sif.core_rst_n, sif.pll_ready, sif.fault}, 32'b1000);
        check("reset_cnt", {24'd0, sif.lock_lost_cnt}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic lose_and_regain(output int n_fall, output int n_rise);
        @(negedge refclk);
        sif.pll_locked = 1'b0;
        edges_until(1, 1'b0, 10, n_fall);
        @(negedge refclk);
        sif.pll_locked = 1'b1;
        edges_until(2, 1'b1, 60, n_rise);
    endtask

    int n, n2, seg;

    initial begin
        rst_n           = 1'b0;
        sif.pll_locked  = 1'b0;
        sif.clear_fault = 1'b0;

        // Locked from the start: clean release.
        sif.pll_locked = 1'b1;
        do_reset();
        edges_until(0, 1'b0, 20, n);
        check("t1_pll_rst_fall_edge", n, 4);
        edges_until(1, 1'b1, 50, n2);
        check("t1_core_release_after_fall", n2, 9);
        check("t1_ready", {31'd0, sif.pll_ready}, 1);
        check("t1_fault", {31'd0, sif.fault}, 0);

        // Never locks: three attempts then FAULT.
        @(negedge refclk);
        sif.pll_locked = 1'b0;
        do_reset();
        edges_until(3, 1'b1, 400, n);
        check("t2_fault_edge", n, 162);
        check("t2_pll_rst_in_fault", {31'd0, sif.pll_rst}, 1);
        repeat (10) @(posedge refclk);
        #1;
        check("t2_fault_held", {31'd0, sif.fault}, 1);
        @(negedge refclk);
        sif.clear_fault = 1'b1;
        @(posedge refclk);
        #1;
        check("t2_fault_cleared", {30'd0, sif.fault, sif.pll_rst}, 32'b01);
        @(negedge refclk);
        sif.clear_fault = 1'b0;

        // One-cycle lock glitch while qualifying.
        sif.pll_locked = 1'b1;
        do_reset();
        repeat (10) @(posedge refclk);
        @(negedge refclk);
        sif.pll_locked = 1'b0;
        @(negedge refclk);
        sif.pll_locked = 1'b1;
        edges_until(0, 1'b1, 10, n);
        check("t3_back_to_pll_rst", n, 2);
        check("t3_core_held", {31'd0, sif.core_rst_n}, 0);
        edges_until(1, 1'b1, 40, n);
        check("t3_release_after_retry", n, 13);

        // Lock loss in RUN.
        lose_and_regain(n, n2);
        check("t4_loss_latency", n, 3);
        check("t4_rerelease", n2, 13);
        check("t4_cnt", {24'd0, sif.lock_lost_cnt}, 1);

        // Build count to 7, then reset in the middle of STABLE.
        for (int i = 0; i < 5; i++) lose_and_regain(n, n2);
        @(negedge refclk);
        sif.pll_locked = 1'b0;
        edges_until(1, 1'b0, 10, n);
        @(negedge refclk);
        sif.pll_locked = 1'b1;
        check("t5_cnt_before", {24'd0, sif.lock_lost_cnt}, 7);
        repeat (8) @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b0;
        @(posedge refclk);
        #1;
        check("t5_reset_outputs",
              {20'd0, sif.pll_rst, sif.core_rst_n, sif.pll_ready, sif.fault, sif.lock_lost_cnt},
              32'h800);
        @(negedge refclk);
        rst_n = 1'b1;

        // Saturation of the lock-loss counter.
        edges_until(2, 1'b1, 60, n);
        for (int i = 0; i < 260; i++) begin
            lose_and_regain(n, n2);
            if (n < 0 || n2 < 0) break;
        end
        check("t6_cnt_saturated", {24'd0, sif.lock_lost_cnt}, 255);
        lose_and_regain(n, n2);
        check("t6_cnt_held", {24'd0, sif.lock_lost_cnt}, 255);

        // Randomized lock behaviour, clear pulses and occasional resets.
        seg = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge refclk);
            if (seg == 0) begin
                sif.pll_locked = ($urandom_range(0, 9) < 7);
                seg = $urandom_range(1, 70);
            end
            seg--;
            sif.clear_fault = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
        end
        @(negedge refclk);
        sif.clear_fault = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge refclk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
